// File: rtl/alu_pkg.sv
// Shared op-codes, FSM state encoding and op classification for the chunked ALU.
package alu_pkg;
  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_BEQ = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_BEQ) || (op == OP_SLT);
  endfunction
endpackage

// File: rtl/alu_chunk_slice.sv
// One CHUNK-wide combinational slice: logic ops or a ripple adder with B-invert.
module alu_chunk_slice
  import alu_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic [2:0]       op,
  input  logic             cin,
  output logic [CHUNK-1:0] res,
  output logic             cout,
  output logic             cmsb
);
  logic [CHUNK:0]   c;
  logic [CHUNK-1:0] bx;
  logic [CHUNK-1:0] sum;

  always_comb begin
    bx   = op[2] ? ~b : b;
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int i = 0; i < CHUNK; i++) begin
      sum[i]   = a[i] ^ bx[i] ^ c[i];
      c[i+1]   = (a[i] & bx[i]) | (c[i] & (a[i] ^ bx[i]));
    end
    cout = c[CHUNK];
    // carry into the slice MSB; only meaningful on the top slice for overflow
    cmsb = c[CHUNK-1];
    case (op)
      OP_AND:                         res = a & b;
      OP_OR:                          res = a | b;
      OP_ADD, OP_SUB, OP_BEQ, OP_SLT: res = sum;
      default:                        res = '0;
    endcase
  end
endmodule

// File: rtl/serial_chunk_alu.sv
// Multi-cycle ALU: one CHUNK slice per clock over WIDTH/CHUNK cycles, valid/ready on both sides.
module serial_chunk_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             cout,
  output logic             overflow
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q, res_nx;
  logic [2:0]       op_q;
  logic             carry, arith, last, ovf_nx;
  logic [CW-1:0]    cnt;
  logic [CHUNK-1:0] s_res;
  logic             s_cout, s_cmsb;
  int               base;

  assign base      = int'(cnt) * CHUNK;
  assign last      = (cnt == LAST);
  assign arith     = is_arith(op_q);
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

  alu_chunk_slice #(.CHUNK(CHUNK)) u_slice (
    .a    (a_q[base +: CHUNK]),
    .b    (b_q[base +: CHUNK]),
    .op   (op_q),
    .cin  (carry),
    .res  (s_res),
    .cout (s_cout),
    .cmsb (s_cmsb)
  );

  always_comb begin
    res_nx = result;
    res_nx[base +: CHUNK] = s_res;
    ovf_nx = arith & (s_cmsb ^ s_cout);
    // SLT collapses to less-than on the last slice, once the diff sign is known
    if (last && op_q == OP_SLT) res_nx = WIDTH'(res_nx[WIDTH-1] ^ ovf_nx);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (in_valid) state_nx = S_BUSY;
      S_BUSY:  if (last) state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_AND;
      carry    <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      zero     <= 1'b0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && in_valid) begin
        a_q   <= a;
        b_q   <= b;
        op_q  <= op;
        carry <= op[2];
        cnt   <= '0;
      end else if (state == S_BUSY) begin
        result <= res_nx;
        carry  <= s_cout;
        cnt    <= cnt + 1'b1;
        if (last) begin
          cout     <= arith & s_cout;
          overflow <= ovf_nx;
          zero     <= (res_nx == '0);
        end
      end
    end
  end
endmodule
